c_stream_receiver: RTL and testbench

Serial-to-parallel receiver for the C result stream. It sits directly downstream of the sequencing controller and consumes the `startC` / `shiftC` / serial-bit stream. Each frame is assembled into a WORD_W-bit word and pushed into a small FIFO. Words are presented to the consumer through a valid/ready handshake, and full-FIFO overflow and broken frames are flagged.

---
 rtl/c_stream_receiver.sv | 125 ++++++++++++
 tb/tb_c_stream_receiver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/c_stream_receiver.sv
// Serial-to-parallel receiver for the C result stream: assembles LSB-first frames
// into WORD_W-bit words and queues them in a small FIFO behind a valid/ready port.
module c_stream_receiver #(
  parameter int WORD_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          startC,
  input  logic                          shiftC,
  input  logic                          serC,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]   shreg_q, shreg_d;
  logic                frame_err_q, frame_err_d;
  logic                push;
  logic [WORD_W-1:0]   push_word;

  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                overflow_q;
  logic                pop, full, wr_en, drop;

  // Deserializer: the last bit bypasses the shift register straight into the word.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_word   = {serC, shreg_q};
    case (state_q)
      IDLE: begin
        if (shiftC && startC) begin
          shreg_d[0] = serC;
          bit_cnt_d  = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (shiftC) begin
          if (startC) begin
            frame_err_d = 1'b1;
            shreg_d[0]  = serC;
            bit_cnt_d   = CNT_W'(1);
          end else if (bit_cnt_q == LAST_BIT) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            for (int i = 1; i < WORD_W - 1; i++) begin
              if (bit_cnt_q == CNT_W'(i)) shreg_d[i] = serC;
            end
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // A push at full still lands when the head is popped in the same cycle.
  assign pop   = out_valid && out_ready;
  assign full  = (level_q == FULL_LVL);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      level_q    <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
      overflow_q <= overflow_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (level_q != '0);
  assign fifo_level = level_q;
  assign busy       = (state_q == SHIFT);
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_c_stream_receiver.sv
// Bench for c_stream_receiver: queue scoreboard of expected FIFO contents plus a
// small frame table and hand-written multi-cycle sequences.
module tb_c_stream_receiver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       startC = 1'b0, shiftC = 1'b0, serC = 1'b0, out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_valid, busy, overflow, frame_err;
  logic [2:0] fifo_level;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  typedef struct {
    logic [3:0] word;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;
  vec_t tbl[5];

  c_stream_receiver #(.WORD_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .startC(startC), .shiftC(shiftC), .serC(serC),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .busy(busy), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: pop-compare before the edge, drive inputs, update model, check after edge.
  task automatic cyc(input logic sh, input logic st, input logic se,
                     input logic push, input logic [3:0] w);
    if (out_ready && exp_q.size() != 0) begin
      chk("pop_valid", 32'(out_valid), 32'd1);
      chk("pop_data", 32'(out_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    shiftC = sh; startC = st; serC = se;
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    chk("level", 32'(fifo_level), 32'(exp_q.size()));
    chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    idle(n);
    out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w, input int stall, input logic last_rdy);
    out_ready = 1'b0;
    cyc(1'b1, 1'b1, w[0], 1'b0, w);
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc(1'b1, 1'b0, w[1], 1'b0, w);
    cyc(1'b1, 1'b0, w[2], 1'b0, w);
    for (int s = 0; s < stall; s++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, w);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    out_ready = last_rdy;
    cyc(1'b1, 1'b0, w[3], 1'b1, w);
    out_ready = 1'b0;
    chk("busy_after_last", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    tbl[0] = '{word: 4'h1, lvl: 3'd1, ovf: 1'b0};
    tbl[1] = '{word: 4'h2, lvl: 3'd2, ovf: 1'b0};
    tbl[2] = '{word: 4'h3, lvl: 3'd3, ovf: 1'b0};
    tbl[3] = '{word: 4'h4, lvl: 3'd4, ovf: 1'b0};
    tbl[4] = '{word: 4'h5, lvl: 3'd4, ovf: 1'b1};

    // Power-on reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Stray bit in IDLE is ignored
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("stray_busy", 32'(busy), 32'd0);

    // Single frame 4'b1011
    send_frame(4'b1011, 0, 1'b0);
    chk("single_data", 32'(out_data), 32'hB);
    chk("single_level", 32'(fifo_level), 32'd1);
    drain(2);

    // Stalled frame
    send_frame(4'b1011, 3, 1'b0);
    chk("stall_data", 32'(out_data), 32'hB);
    drain(2);

    // Overflow: five back-to-back frames with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].word, 0, 1'b0);
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].lvl));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
    end
    drain(5);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset with two words stored and a half frame shifted
    send_frame(4'h9, 0, 1'b0);
    send_frame(4'h6, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    shiftC = 1'b0; startC = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_frame(4'b0110, 0, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h6);
    drain(2);

    // Push and pop in the same cycle at full
    for (int i = 0; i < 4; i++) send_frame(tbl[i].word, 0, 1'b0);
    send_frame(4'h5, 0, 1'b1);
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    drain(5);

    // Frame error: restart after two bits
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ferr_idle", 32'(frame_err), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_busy", 32'(busy), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("ferr_clear", 32'(frame_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b1110);
    chk("ferr_data", 32'(out_data), 32'hE);
    chk("ferr_level", 32'(fifo_level), 32'd1);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
